// File: rtl/cmos_pkg.sv
// Shared state encoding, default timing and timer helpers for the CMOS sensor power sequencer.
package cmos_pkg;

  localparam int TMR_W = 20;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PWDN_HOLD = 3'd1;
  localparam logic [2:0] ST_RST_HOLD  = 3'd2;
  localparam logic [2:0] ST_WAIT      = 3'd3;
  localparam logic [2:0] ST_READY     = 3'd4;

  localparam logic [TMR_W-1:0] T_PWDN_DEF = 20'd4096;
  localparam logic [TMR_W-1:0] T_RST_DEF  = 20'd4096;
  localparam logic [TMR_W-1:0] T_WAIT_DEF = 20'hffff0;

  // A zero-length hold still occupies its state for one cycle.
  function automatic logic [TMR_W-1:0] hold_len(input logic [TMR_W-1:0] n);
    return (n == 20'd0) ? 20'd1 : n;
  endfunction

endpackage

// File: rtl/cmos_seq_timer.sv
// Loadable 20-bit down-counter; saturates at zero, done while one or fewer cycles remain.
module cmos_seq_timer
  import cmos_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             done_o
);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 20'd0) begin
      cnt_d = cnt_q - 20'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 20'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q <= 20'd1);

endmodule

// File: rtl/cmos_pwr_seq.sv
// CMOS camera power-up sequencer: PWDN hold, RESET# hold, settle, then ready.
// Optional CMOS_PWR_SEQ_AUTOSTART_EN: implicit start on the first edge after reset.
module cmos_pwr_seq
  import cmos_pkg::*;
#(
  parameter logic [TMR_W-1:0] T_PWDN = T_PWDN_DEF,
  parameter logic [TMR_W-1:0] T_RST  = T_RST_DEF,
  parameter logic [TMR_W-1:0] T_WAIT = T_WAIT_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic stop_i,
  output logic cam_pwdn_o,
  output logic cam_rst_n_o,
  output logic ready_o,
  output logic busy_o
);

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_PWDN_HOLD = ST_PWDN_HOLD,
    S_RST_HOLD  = ST_RST_HOLD,
    S_WAIT      = ST_WAIT,
    S_READY     = ST_READY
  } state_e;

  state_e           state_q, state_d;
  logic             pwdn_q, pwdn_d, rst_n_q, rst_n_d, ready_q, ready_d, busy_q, busy_d;
  logic             tmr_load, tmr_done, start_eff;
  logic [TMR_W-1:0] tmr_val;

`ifdef CMOS_PWR_SEQ_AUTOSTART_EN
  logic auto_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= 1'b0;
    end
  end

  assign start_eff = start_i | auto_q;
`else
  assign start_eff = start_i;
`endif

  cmos_seq_timer u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Timer loads on the edge that enters a timed state, so it is valid in that state's first cycle.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = 20'd0;
    if (stop_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_eff && !stop_i) begin
            state_d  = S_PWDN_HOLD;
            tmr_load = 1'b1;
            tmr_val  = hold_len(T_PWDN);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PWDN_HOLD: begin
          if (tmr_done) begin
            state_d  = S_RST_HOLD;
            tmr_load = 1'b1;
            tmr_val  = hold_len(T_RST);
          end else begin
            state_d = S_PWDN_HOLD;
          end
        end
        S_RST_HOLD: begin
          if (tmr_done) begin
            state_d  = S_WAIT;
            tmr_load = 1'b1;
            tmr_val  = hold_len(T_WAIT);
          end else begin
            state_d = S_RST_HOLD;
          end
        end
        S_WAIT: begin
          if (tmr_done) begin
            state_d = S_READY;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_READY: state_d = S_READY;
        default: state_d = S_IDLE;
      endcase
    end

    case (state_d)
      S_IDLE:      {pwdn_d, rst_n_d, ready_d, busy_d} = 4'b1000;
      S_PWDN_HOLD: {pwdn_d, rst_n_d, ready_d, busy_d} = 4'b1001;
      S_RST_HOLD:  {pwdn_d, rst_n_d, ready_d, busy_d} = 4'b0001;
      S_WAIT:      {pwdn_d, rst_n_d, ready_d, busy_d} = 4'b0101;
      S_READY:     {pwdn_d, rst_n_d, ready_d, busy_d} = 4'b0110;
      default:     {pwdn_d, rst_n_d, ready_d, busy_d} = 4'b1000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pwdn_q  <= 1'b1;
      rst_n_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwdn_q  <= pwdn_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign cam_pwdn_o  = pwdn_q;
  assign cam_rst_n_o = rst_n_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_cmos_pwr_seq.sv
// Bench for cmos_pwr_seq: T_PWDN=4, T_RST=3 (and a T_RST=0 copy), T_WAIT=5.
module tb_cmos_pwr_seq;

  localparam logic [3:0] O_IDLE = 4'b1000;
  localparam logic [3:0] O_PWDN = 4'b1001;
  localparam logic [3:0] O_RST  = 4'b0001;
  localparam logic [3:0] O_WAIT = 4'b0101;
  localparam logic [3:0] O_RDY  = 4'b0110;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic pwdn_a, rstn_a, ready_a, busy_a;
  logic pwdn_b, rstn_b, ready_b, busy_b;

  typedef struct {
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] exp;
    logic [3:0] exp0;
    logic [1:0] mask;
    string      name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cmos_pwr_seq #(.T_PWDN(20'd4), .T_RST(20'd3), .T_WAIT(20'd5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .cam_pwdn_o(pwdn_a), .cam_rst_n_o(rstn_a), .ready_o(ready_a), .busy_o(busy_a)
  );

  cmos_pwr_seq #(.T_PWDN(20'd4), .T_RST(20'd0), .T_WAIT(20'd5)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop),
    .cam_pwdn_o(pwdn_b), .cam_rst_n_o(rstn_b), .ready_o(ready_b), .busy_o(busy_b)
  );

  // Expected outputs m edges after the start edge, for a given effective RST_HOLD length.
  function automatic logic [3:0] exp_at(input int m, input int trst);
    if (m < 4) return O_PWDN;
    else if (m < 4 + trst) return O_RST;
    else if (m < 4 + trst + 5) return O_WAIT;
    else return O_RDY;
  endfunction

  task automatic add(input logic r, input logic s, input logic p, input logic [3:0] e,
                     input logic [3:0] e0, input logic [1:0] m, input string n);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.exp = e; v.exp0 = e0; v.mask = m; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    vec_t got;
    rst = v.rst; start = v.start; stop = v.stop;
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    if (got.mask[0]) begin
      checks++;
      if ({pwdn_a, rstn_a, ready_a, busy_a} !== got.exp) begin
        failures++;
        $display("FAIL %s dut {pwdn,rstn,ready,busy} got=%b exp=%b", got.name,
                 {pwdn_a, rstn_a, ready_a, busy_a}, got.exp);
      end
    end
    if (got.mask[1]) begin
      checks++;
      if ({pwdn_b, rstn_b, ready_b, busy_b} !== got.exp0) begin
        failures++;
        $display("FAIL %s dut0 {pwdn,rstn,ready,busy} got=%b exp=%b", got.name,
                 {pwdn_b, rstn_b, ready_b, busy_b}, got.exp0);
      end
    end
  endtask

  task automatic run_table();
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
`ifdef CMOS_PWR_SEQ_AUTOSTART_EN
    add(1'b1, 1'b0, 1'b0, O_IDLE, O_IDLE, 2'b11, "as_reset");
    for (int m = 0; m <= 14; m++)
      add(1'b0, 1'b0, 1'b0, exp_at(m, 3), exp_at(m, 1), 2'b11, "autostart");
    run_table();
`else
    add(1'b1, 1'b0, 1'b0, O_IDLE, O_IDLE, 2'b11, "reset_state");
    add(1'b1, 1'b1, 1'b0, O_IDLE, O_IDLE, 2'b11, "reset_ignores_start");
    add(1'b0, 1'b0, 1'b0, O_IDLE, O_IDLE, 2'b11, "idle_no_start");
    add(1'b0, 1'b1, 1'b1, O_IDLE, O_IDLE, 2'b11, "start_stop_in_idle");
    // start held high through the whole run: ignored outside IDLE
    for (int m = 0; m <= 13; m++)
      add(1'b0, 1'b1, 1'b0, exp_at(m, 3), 4'd0, 2'b01, "seq_start_held");
    add(1'b0, 1'b0, 1'b0, O_RDY, 4'd0, 2'b01, "ready_stays");
    add(1'b0, 1'b1, 1'b1, O_IDLE, 4'd0, 2'b01, "stop_wins_ready");
    add(1'b0, 1'b1, 1'b0, O_PWDN, 4'd0, 2'b01, "level_rerun");
    add(1'b0, 1'b0, 1'b0, O_PWDN, 4'd0, 2'b01, "level_rerun_hold");
    add(1'b0, 1'b1, 1'b1, O_IDLE, 4'd0, 2'b01, "stop_in_pwdn");
    add(1'b0, 1'b0, 1'b0, O_IDLE, 4'd0, 2'b01, "idle_after_stop");
    // stop at edge k+6 during RST_HOLD
    for (int m = 0; m <= 5; m++)
      add(1'b0, (m == 0) ? 1'b1 : 1'b0, 1'b0, exp_at(m, 3), 4'd0, 2'b01, "pre_stop_rst");
    add(1'b0, 1'b0, 1'b1, O_IDLE, 4'd0, 2'b01, "stop_in_rst");
    add(1'b0, 1'b0, 1'b0, O_IDLE, 4'd0, 2'b01, "idle_after_stop_rst");
    run_table();

    // Reset at edge k+9 mid-WAIT, then a fresh full sequence.
    apply('{1'b1, 1'b0, 1'b0, O_IDLE, O_IDLE, 2'b11, "rst_pre"});
    for (int m = 0; m <= 8; m++)
      apply('{1'b0, (m == 0) ? 1'b1 : 1'b0, 1'b0, exp_at(m, 3), 4'd0, 2'b01, "pre_abort"});
    apply('{1'b1, 1'b1, 1'b1, O_IDLE, 4'd0, 2'b01, "rst_abort_wait"});
    for (int m = 0; m <= 13; m++)
      apply('{1'b0, (m == 0) ? 1'b1 : 1'b0, 1'b0, exp_at(m, 3), 4'd0, 2'b01, "restart_after_rst"});

    // T_RST=0 copy: RST_HOLD lasts one cycle, ready at k+11.
    apply('{1'b1, 1'b0, 1'b0, O_IDLE, O_IDLE, 2'b11, "rst_both"});
    for (int m = 0; m <= 12; m++)
      apply('{1'b0, (m == 0) ? 1'b1 : 1'b0, 1'b0, exp_at(m, 3), exp_at(m, 1), 2'b11, "trst0_seq"});
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cmos_pwr_seq.md
CMOS_PWR_SEQ -- requirements
Module: cmos_pwr_seq

Interface
REQ-001 SHALL have parameter T_PWDN, default 20'd4096, meaning cycles the camera is held in power-down after start.
REQ-002 SHALL have parameter T_RST, default 20'd4096, meaning cycles cam_rst_n_o is held low after power-down release.
REQ-003 SHALL have parameter T_WAIT, default 20'hffff0, meaning settle cycles after reset release before ready.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port start_i, input, 1 bit: power-up request, sampled in IDLE only.
REQ-007 SHALL have port stop_i, input, 1 bit: power-down request, sampled in every state.
REQ-008 SHALL have port cam_pwdn_o, output, 1 bit: camera PWDN pin, high means powered down.
REQ-009 SHALL have port cam_rst_n_o, output, 1 bit: camera RESET# pin, active low.
REQ-010 SHALL have port ready_o, output, 1 bit: high while the sensor is released and settled, gating the SCCB configuration master.
REQ-011 SHALL have port busy_o, output, 1 bit: high in PWDN_HOLD, RST_HOLD and WAIT.

Function
REQ-012 SHALL implement FSM states IDLE, PWDN_HOLD, RST_HOLD, WAIT and READY.
REQ-013 SHALL drive Moore outputs registered with the state: IDLE/PWDN_HOLD pwdn=1, rst_n=0; RST_HOLD pwdn=0, rst_n=0; WAIT/READY pwdn=0, rst_n=1; ready_o=1 only in READY.
REQ-014 SHALL move IDLE->PWDN_HOLD on the edge where start_i=1 and stop_i=0.
REQ-015 SHALL keep each timed state for exactly max(N,1) cycles, with N the matching parameter, then advance PWDN_HOLD->RST_HOLD->WAIT->READY.
REQ-016 SHALL stay in READY until stop_i=1.
REQ-017 SHALL go to IDLE on the next edge from any non-IDLE state when stop_i=1; stop_i wins over start_i when both are high.
REQ-018 SHALL ignore start_i outside IDLE.
REQ-019 SHALL ignore a start_i held high in READY; a level held high after stop re-runs the sequence from IDLE.
REQ-020 SHALL use a 20-bit state timer that loads on state entry and never wraps; the count compare is unsigned.

Reset
REQ-021 SHALL, while rst_i=1 at an edge, enter IDLE, clear the timer, and set cam_pwdn_o=1, cam_rst_n_o=0, ready_o=0 and busy_o=0 on that edge.
REQ-022 SHALL let rst_i mid-sequence abort to IDLE regardless of start_i and stop_i.

Configuration
REQ-023 SHALL, with CMOS_PWR_SEQ_AUTOSTART_EN defined, treat start_i as 1 on the first edge after rst_i deasserts, so a power-up runs with no external request; start_i stays functional afterwards.
REQ-024 SHALL, without CMOS_PWR_SEQ_AUTOSTART_EN, leave the FSM in IDLE until start_i=1.

Structure
REQ-025 SHALL take the state encoding (3-bit localparams) and the default timing constants from shared package cmos_pkg.
REQ-026 SHALL place the timer in sub-module cmos_seq_timer, a loadable 20-bit down-counter with a done flag; the FSM stays in cmos_pwr_seq.

Verification (T_PWDN=4, T_RST=3, T_WAIT=5, macro undefined)
REQ-027 SHALL check that start_i pulsed at edge k gives PWDN_HOLD in cycles k+1..k+4, RST_HOLD in k+5..k+7, WAIT in k+8..k+12, and ready_o=1 from k+13.
REQ-028 SHALL check that stop_i=1 at edge k+6, during RST_HOLD, gives cam_pwdn_o=1, cam_rst_n_o=0 and busy_o=0 from k+7.
REQ-029 SHALL check that start_i=stop_i=1 in IDLE leaves the FSM in IDLE with outputs unchanged.
REQ-030 SHALL check that rst_i=1 at edge k+9 gives IDLE outputs at k+10, and that a new start restarts the full 12-cycle sequence.
REQ-031 SHALL check that T_RST=0 makes RST_HOLD last exactly 1 cycle, so ready_o=1 at k+11.
REQ-032 SHALL check that, with CMOS_PWR_SEQ_AUTOSTART_EN defined, rst_i deasserting before edge r gives ready_o=1 at r+13 with start_i tied 0.
